// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage RAW hazard scoreboard: FSM state, tracker entry, x0 constant.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } hs_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } trk_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A read source only conflicts if it is actually read and is not x0.
    function automatic logic src_match(input logic used, input logic [4:0] src,
                                       input trk_entry_t e);
        return used && (src != REG_ZERO) && e.valid && (src == e.rd);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter used for the scoreboard performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline RAW hazard scoreboard with redirect flush and memory-busy freeze.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int HAZ_DEPTH = 3,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_rd_wren_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // trk[0] is EX, trk[HAZ_DEPTH-1] is WB
    trk_entry_t [HAZ_DEPTH-1:0] trk;
    logic       [HAZ_DEPTH-1:0] hit;
    logic                       raw_hit;
    trk_entry_t                 id_entry;
    hs_state_e                  state_q, state_d;

    for (genvar g = 0; g < HAZ_DEPTH; g++) begin : g_hit
        assign hit[g] = src_match(id_rs1_used_i, id_rs1_addr_i, trk[g]) |
                        src_match(id_rs2_used_i, id_rs2_addr_i, trk[g]);
    end

    // No register-file write-through, so the WB entry still counts as a hazard.
    assign raw_hit = id_valid_i & (|hit);

    always_comb begin
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        flush_o  = 1'b0;
        state_d  = ST_RUN;
        if (mem_busy_i) begin
            stall_o = 1'b1;
            state_d = ST_MEMWAIT;
        end else if (ex_redirect_i) begin
            flush_o  = 1'b1;
            bubble_o = 1'b1;
            state_d  = ST_FLUSH;
        end else if (raw_hit) begin
            stall_o  = 1'b1;
            bubble_o = 1'b1;
            state_d  = ST_STALL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;

    always_comb begin
        id_entry.valid = id_valid_i & id_rd_wren_i & (id_rd_addr_i != REG_ZERO);
        id_entry.rd    = id_rd_addr_i;
        if (bubble_o)
            id_entry = '0;
    end

    // A redirect only bubbles entry 0; the branch already in EX keeps its rd (JAL/JALR).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trk <= '0;
        end else if (!mem_busy_i) begin
            trk[0] <= id_entry;
            for (int i = 1; i < HAZ_DEPTH; i++)
                trk[i] <= trk[i-1];
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .gclk   (clk_i),
        .grst_n (rst_ni),
        .inc    (state_d == ST_STALL),
        .cnt    (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .gclk   (clk_i),
        .grst_n (rst_ni),
        .inc    (state_d == ST_FLUSH),
        .cnt    (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic vs a pending-write model.
module tb_hazard_scoreboard;

    localparam int D  = 3;
    localparam int CW = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_u1, id_u2, id_wren, redirect, busy;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          stall_o, bubble_o, flush_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    hazard_scoreboard #(.HAZ_DEPTH(D), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .id_valid_i    (id_valid),
        .id_rs1_addr_i (id_rs1),
        .id_rs2_addr_i (id_rs2),
        .id_rs1_used_i (id_u1),
        .id_rs2_used_i (id_u2),
        .id_rd_addr_i  (id_rd),
        .id_rd_wren_i  (id_wren),
        .ex_redirect_i (redirect),
        .mem_busy_i    (busy),
        .stall_o       (stall_o),
        .bubble_o      (bubble_o),
        .flush_o       (flush_o),
        .state_o       (state_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: list of outstanding register writes with cycles left before they retire.
    int            pend_rd[$];
    int            pend_left[$];
    int            m_state;
    logic [CW-1:0] m_scnt, m_fcnt;

    function automatic bit m_raw();
        if (!id_valid) return 1'b0;
        foreach (pend_rd[k]) begin
            if (id_u1 && id_rs1 != 0 && int'(id_rs1) == pend_rd[k]) return 1'b1;
            if (id_u2 && id_rs2 != 0 && int'(id_rs2) == pend_rd[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // 3 = memory wait, 2 = redirect, 1 = RAW stall, 0 = run
    function automatic int m_branch();
        if (busy)     return 3;
        if (redirect) return 2;
        if (m_raw())  return 1;
        return 0;
    endfunction

    task automatic m_clear();
        pend_rd.delete();
        pend_left.delete();
        m_state = 0;
        m_scnt  = '0;
        m_fcnt  = '0;
    endtask

    task automatic tick();
        int b = m_branch();
        if (b != 3) begin
            for (int k = pend_left.size() - 1; k >= 0; k--) begin
                pend_left[k] = pend_left[k] - 1;
                if (pend_left[k] == 0) begin
                    pend_left.delete(k);
                    pend_rd.delete(k);
                end
            end
            if (b == 0 && id_valid && id_wren && id_rd != 0) begin
                pend_rd.push_back(int'(id_rd));
                pend_left.push_back(D);
            end
        end
        m_state = b;
        if (PERF && b == 1 && m_scnt != '1) m_scnt = m_scnt + 1'b1;
        if (PERF && b == 2 && m_fcnt != '1) m_fcnt = m_fcnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_u1 = 0; id_u2 = 0; id_wren = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        redirect = 0; busy = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic wren);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_u1 = u1; id_u2 = u2;
        id_rd = rd; id_wren = wren;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        n_cmp++; if (bubble_o !== 1'b0) begin n_err++; $display("FAIL reset_bubble: got %b expected 0", bubble_o); end
        n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b expected 0", flush_o); end
        n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        n_cmp++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt_o, flush_cnt_o); end
        redirect = 1;
        #1;
        n_cmp++; if ({flush_o, bubble_o, stall_o} !== 3'b110) begin n_err++; $display("FAIL empty_redirect: got %b expected 110", {flush_o, bubble_o, stall_o}); end
        redirect = 0; busy = 1;
        #1;
        n_cmp++; if ({flush_o, bubble_o, stall_o} !== 3'b001) begin n_err++; $display("FAIL empty_busy: got %b expected 001", {flush_o, bubble_o, stall_o}); end
        busy = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(5'd1, 5'd2, 1, 1, 5'd5, 1);
        #2;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL b2b_producer: got %b expected 0", stall_o); end
        tick();
        set_id(5'd5, 5'd1, 1, 1, 5'd6, 1);
        for (int k = 0; k < 3; k++) begin
            #2;
            n_cmp++; if ({stall_o, bubble_o} !== 2'b11) begin n_err++; $display("FAIL b2b_stall%0d: got %b expected 11", k, {stall_o, bubble_o}); end
            tick();
            if (k == 0) begin
                n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL b2b_state: got %0d expected 1", state_o); end
            end
        end
        #2;
        n_cmp++; if ({stall_o, bubble_o} !== 2'b00) begin n_err++; $display("FAIL b2b_issue: got %b expected 00", {stall_o, bubble_o}); end
        tick();
        set_idle();
        n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL b2b_run: got %0d expected 0", state_o); end
        n_cmp++; if (stall_cnt_o !== (PERF ? CW'(3) : CW'(0))) begin n_err++; $display("FAIL b2b_cnt: got %0d expected %0d", stall_cnt_o, PERF ? 3 : 0); end
    endtask

    task automatic test_gaps();
        for (int g = 1; g <= 2; g++) begin
            int n = 0;
            do_reset();
            set_id(5'd1, 5'd2, 1, 1, 5'd5, 1);
            tick();
            set_idle();
            for (int k = 0; k < g; k++) tick();
            set_id(5'd3, 5'd5, 1, 1, 5'd6, 1);
            for (int k = 0; k < 6; k++) begin
                #2;
                if (stall_o !== 1'b1) break;
                n++;
                tick();
            end
            n_cmp++; if (n != 3 - g) begin n_err++; $display("FAIL gap%0d_stalls: got %0d expected %0d", g, n, 3 - g); end
            tick();
        end
    endtask

    task automatic test_x0();
        do_reset();
        set_id(5'd1, 5'd2, 1, 1, 5'd0, 1);
        tick();
        set_id(5'd0, 5'd0, 1, 1, 5'd3, 1);
        #2;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL x0_ex: got %b expected 0", stall_o); end
        tick();
        set_id(5'd4, 5'd0, 0, 1, 5'd0, 0);
        #2;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL x0_mem: got %b expected 0", stall_o); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        set_id(5'd1, 5'd2, 1, 1, 5'd7, 1);
        tick();
        set_id(5'd0, 5'd0, 0, 0, 5'd8, 1);
        tick();
        set_id(5'd7, 5'd0, 1, 0, 5'd10, 1);
        redirect = 1;
        #2;
        n_cmp++; if ({flush_o, bubble_o, stall_o} !== 3'b110) begin n_err++; $display("FAIL redir_out: got %b expected 110", {flush_o, bubble_o, stall_o}); end
        tick();
        n_cmp++; if (state_o !== 2'd2) begin n_err++; $display("FAIL redir_state: got %0d expected 2", state_o); end
        n_cmp++; if (flush_cnt_o !== (PERF ? CW'(1) : CW'(0))) begin n_err++; $display("FAIL redir_cnt: got %0d expected %0d", flush_cnt_o, PERF ? 1 : 0); end
        redirect = 0;
        set_id(5'd8, 5'd0, 1, 0, 5'd0, 0);
        #2;
        n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL redir_keep_mem: got %b expected 1", stall_o); end
        tick();
        #2;
        n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL redir_keep_wb: got %b expected 1", stall_o); end
        tick();
        #2;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL redir_release: got %b expected 0", stall_o); end
        tick();
    endtask

    task automatic test_memwait();
        int n = 0;
        do_reset();
        set_id(5'd1, 5'd2, 1, 1, 5'd9, 1);
        tick();
        set_id(5'd9, 5'd3, 1, 1, 5'd11, 1);
        #2;
        n_cmp++; if ({stall_o, bubble_o} !== 2'b11) begin n_err++; $display("FAIL mw_pre: got %b expected 11", {stall_o, bubble_o}); end
        tick();
        busy = 1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_cmp++; if ({stall_o, bubble_o, flush_o} !== 3'b100) begin n_err++; $display("FAIL mw_out%0d: got %b expected 100", k, {stall_o, bubble_o, flush_o}); end
            tick();
            n_cmp++; if (state_o !== 2'd3) begin n_err++; $display("FAIL mw_state%0d: got %0d expected 3", k, state_o); end
        end
        busy = 0;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (stall_o !== 1'b1) break;
            n++;
            tick();
        end
        n_cmp++; if (n != 2) begin n_err++; $display("FAIL mw_remaining: got %0d expected 2", n); end
        tick();
        n_cmp++; if (stall_cnt_o !== (PERF ? CW'(3) : CW'(0))) begin n_err++; $display("FAIL mw_cnt: got %0d expected %0d", stall_cnt_o, PERF ? 3 : 0); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_id(5'd1, 5'd2, 1, 1, 5'd5, 1);
        tick();
        set_id(5'd5, 5'd0, 1, 0, 5'd6, 1);
        tick();
        #2;
        n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %b expected 1", stall_o); end
        rst_n = 0;
        m_clear();
        #1;
        n_cmp++; if ({stall_o, bubble_o, flush_o} !== 3'b000) begin n_err++; $display("FAIL ar_outs: got %b expected 000", {stall_o, bubble_o, flush_o}); end
        n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL ar_state: got %0d expected 0", state_o); end
        n_cmp++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin n_err++; $display("FAIL ar_cnt: got %0d/%0d expected 0/0", stall_cnt_o, flush_cnt_o); end
        @(posedge clk);
        #1;
        rst_n = 1;
        #2;
        n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL ar_after: got %b expected 0", stall_o); end
        tick();
        n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL ar_state_after: got %0d expected 0", state_o); end
    endtask

    task automatic test_random();
        int b;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1   = 5'($urandom_range(0, 7));
            id_rs2   = 5'($urandom_range(0, 7));
            id_u1    = 1'($urandom_range(0, 1));
            id_u2    = 1'($urandom_range(0, 1));
            id_rd    = 5'($urandom_range(0, 7));
            id_wren  = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 9) == 0);
            busy     = ($urandom_range(0, 7) == 0);
            #2;
            b = m_branch();
            n_cmp++;
            if ({stall_o, bubble_o, flush_o} !== {(b == 1 || b == 3), (b == 1 || b == 2), (b == 2)}) begin
                n_err++;
                $display("FAIL rnd_out c%0d: got %b expected %b", c, {stall_o, bubble_o, flush_o},
                         {(b == 1 || b == 3), (b == 1 || b == 2), (b == 2)});
            end
            tick();
            n_cmp++; if (state_o !== 2'(m_state)) begin n_err++; $display("FAIL rnd_state c%0d: got %0d expected %0d", c, state_o, m_state); end
            n_cmp++; if (stall_cnt_o !== m_scnt || flush_cnt_o !== m_fcnt) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d/%0d expected %0d/%0d", c, stall_cnt_o, flush_cnt_o, m_scnt, m_fcnt); end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_x0();
        test_redirect();
        test_memwait();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
